// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage in front of the execute ALU.
// It decodes RV32I OP, OP-IMM, LUI and AUIPC into ALU operands and a
// function select, and holds the result in a valid/ready output register.
// The ALU result of the held instruction is forwarded into the operands
// of the instruction being accepted when the register indices match.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int OP     = 3,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] alu_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP-1:0]     out_s,
    output logic              out_ext,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wb_en,
    output logic              out_illegal,
    output logic [DATA_W-1:0] out_pc
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Output register state
    logic              valid_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [OP-1:0]     s_r;
    logic              ext_r;
    logic [REG_W-1:0]  rd_r;
    logic              wb_en_r;
    logic              illegal_r;
    logic [DATA_W-1:0] pc_r;

    // Decode results for the incoming instruction
    logic [6:0]        opcode_s;
    logic [2:0]        f3_s;
    logic [REG_W-1:0]  rd_idx_s;
    logic [REG_W-1:0]  rs1_idx_s;
    logic [REG_W-1:0]  rs2_idx_s;
    logic              held_s;
    logic              fwd1_s;
    logic              fwd2_s;
    logic [DATA_W-1:0] rs1_val_s;
    logic [DATA_W-1:0] rs2_val_s;
    logic signed [11:0] imm_i12_s;
    logic signed [31:0] imm_u32_s;
    logic [DATA_W-1:0] imm_i_s;
    logic [DATA_W-1:0] imm_u_s;
    logic [DATA_W-1:0] dec_a_s;
    logic [DATA_W-1:0] dec_b_s;
    logic [2:0]        dec_s_s;
    logic              dec_ext_s;
    logic              dec_illegal_s;
    logic              dec_wb_en_s;
    logic              transfer_s;

    assign in_ready   = !valid_r || out_ready;
    assign transfer_s = in_valid && in_ready;

    // Field extraction, immediates and forwarding operand selection
    always_comb begin
        opcode_s  = in_instr[6:0];
        f3_s      = in_instr[14:12];
        rd_idx_s  = in_instr[11:7];
        rs1_idx_s = in_instr[19:15];
        rs2_idx_s = in_instr[24:20];
        imm_i12_s = in_instr[31:20];
        imm_u32_s = {in_instr[31:12], 12'b0000_0000_0000};
        imm_i_s   = DATA_W'(imm_i12_s);
        imm_u_s   = DATA_W'(imm_u32_s);
        // Only a valid, writing, non-x0 instruction can be a forwarding source
        held_s    = valid_r && wb_en_r && (rd_r != {REG_W{1'b0}});
        fwd1_s    = held_s && (rs1_idx_s == rd_r);
        fwd2_s    = held_s && (rs2_idx_s == rd_r);
        if (fwd1_s) begin
            rs1_val_s = alu_y;
        end else begin
            rs1_val_s = in_rs1_data;
        end
        if (fwd2_s) begin
            rs2_val_s = alu_y;
        end else begin
            rs2_val_s = in_rs2_data;
        end
    end

    // Opcode decode into ALU operands, function select and legality
    always_comb begin
        dec_a_s       = {DATA_W{1'b0}};
        dec_b_s       = {DATA_W{1'b0}};
        dec_s_s       = 3'b000;
        dec_ext_s     = 1'b0;
        dec_illegal_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                if ((f3_s == 3'b010) || (f3_s == 3'b011)) begin
                    dec_illegal_s = 1'b1;
                end else begin
                    dec_a_s   = rs1_val_s;
                    dec_b_s   = rs2_val_s;
                    dec_s_s   = f3_s;
                    dec_ext_s = in_instr[30];
                end
            end
            OPC_OPIMM: begin
                if ((f3_s == 3'b010) || (f3_s == 3'b011)) begin
                    dec_illegal_s = 1'b1;
                end else begin
                    dec_a_s   = rs1_val_s;
                    dec_b_s   = imm_i_s;
                    dec_s_s   = f3_s;
                    // instr[30] is an immediate bit except for SRLI/SRAI
                    if (f3_s == 3'b101) begin
                        dec_ext_s = in_instr[30];
                    end else begin
                        dec_ext_s = 1'b0;
                    end
                end
            end
            OPC_LUI: begin
                dec_a_s = {DATA_W{1'b0}};
                dec_b_s = imm_u_s;
            end
            OPC_AUIPC: begin
                dec_a_s = in_pc;
                dec_b_s = imm_u_s;
            end
            // Every opcode above ends in 2'b11, so other low bits land here
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
        dec_wb_en_s = !dec_illegal_s && (rd_idx_s != {REG_W{1'b0}});
    end

    // Output register: flush beats transfer, transfer beats drain, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            a_r       <= {DATA_W{1'b0}};
            b_r       <= {DATA_W{1'b0}};
            s_r       <= {OP{1'b0}};
            ext_r     <= 1'b0;
            rd_r      <= {REG_W{1'b0}};
            wb_en_r   <= 1'b0;
            illegal_r <= 1'b0;
            pc_r      <= {DATA_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (transfer_s) begin
            valid_r   <= 1'b1;
            a_r       <= dec_a_s;
            b_r       <= dec_b_s;
            s_r       <= OP'(dec_s_s);
            ext_r     <= dec_ext_s;
            rd_r      <= rd_idx_s;
            wb_en_r   <= dec_wb_en_s;
            illegal_r <= dec_illegal_s;
            pc_r      <= in_pc;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid   = valid_r;
    assign out_a       = a_r;
    assign out_b       = b_r;
    assign out_s       = s_r;
    assign out_ext     = ext_r;
    assign out_rd      = rd_r;
    assign out_wb_en   = wb_en_r;
    assign out_illegal = illegal_r;
    assign out_pc      = pc_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed vectors with hand-computed
// expectations pushed into a queue; a negedge monitor pops and compares
// each output the execute stage consumes.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] alu_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_s;
    logic        out_ext;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_illegal;
    logic [31:0] out_pc;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  s;
        logic        ext;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    alu_issue_stage #(.DATA_W(32), .OP(3), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .alu_y(alu_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_s(out_s), .out_ext(out_ext),
        .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal),
        .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every consumed output must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_a", out_a, e.a);
                check("out_b", out_b, e.b);
                check("out_s", {29'd0, out_s}, {29'd0, e.s});
                check("out_ext", {31'd0, out_ext}, {31'd0, e.ext});
                check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                check("out_wb_en", {31'd0, out_wb_en}, {31'd0, e.wb});
                check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                check("out_pc", out_pc, e.pc);
            end
        end
    end

    // Present one instruction for a cycle; optionally record its expected result
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] y,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] es,
                         input logic ee, input logic [4:0] erd, input logic ewb,
                         input logic eil, input bit push);
        exp_t e;
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        alu_y       = y;
        e.a = ea; e.b = eb; e.s = es; e.ext = ee; e.rd = erd; e.wb = ewb; e.ill = eil; e.pc = pc;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        alu_y    = 32'hDEAD_BEEF;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    localparam logic [31:0] Y0 = 32'hDEAD_BEEF;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;
        alu_y = Y0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_b", out_b, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode vectors, back to back
        issue(32'h002081B3, 32'h00, 32'd5, 32'd7, Y0, 32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        issue(32'h402081B3, 32'h10, 32'd5, 32'd7, Y0, 32'd5, 32'd7, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        issue(32'h40335293, 32'h20, 32'h8000_0000, 32'd9, Y0, 32'h8000_0000, 32'h0000_0403, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        issue(32'hFFF00093, 32'h30, 32'd0, 32'd9, Y0, 32'd0, 32'hFFFF_FFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
        issue(32'h123453B7, 32'h40, 32'h11, 32'h22, Y0, 32'd0, 32'h1234_5000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        issue(32'h12345397, 32'h100, 32'h11, 32'h22, Y0, 32'h100, 32'h1234_5000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        issue(32'h00000013, 32'h60, 32'd0, 32'd0, Y0, 32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(32'h0020A1B3, 32'h70, 32'd5, 32'd7, Y0, 32'd0, 32'd0, 3'b000, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
        issue(32'h00000000, 32'h80, 32'd5, 32'd7, Y0, 32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Forwarding: both operands from held x3, then no forwarding from held x0
        issue(32'h002081B3, 32'h200, 32'd5, 32'd7, Y0, 32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        issue(32'h00318233, 32'h204, 32'd99, 32'd99, 32'd12, 32'd12, 32'd12, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        issue(32'h00000033, 32'h208, 32'd0, 32'd0, Y0, 32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(32'h00000233, 32'h20C, 32'd99, 32'd99, 32'd12, 32'd99, 32'd99, 3'b000, 1'b0, 5'd4, 1'b0 | 1'b1, 1'b0, 1'b1);
        idle(2);

        // Backpressure: hold ADDI x1 while SUB x3,x1,x2 waits, rs1 forwards on accept
        issue(32'hFFF00093, 32'h300, 32'd0, 32'd0, Y0, 32'd0, 32'hFFFF_FFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_instr    = 32'h402081B3;
        in_pc       = 32'h304;
        in_rs1_data = 32'd20;
        in_rs2_data = 32'd3;
        alu_y       = 32'h55;
        begin
            exp_t e;
            e.a = 32'h55; e.b = 32'd3; e.s = 3'b000; e.ext = 1'b1; e.rd = 5'd3;
            e.wb = 1'b1; e.ill = 1'b0; e.pc = 32'h304;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_b", out_b, 32'hFFFF_FFFF);
            check("bp_out_rd", {27'd0, out_rd}, 32'd1);
            check("bp_out_pc", out_pc, 32'h300);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Flush while stalled drops both held and incoming instructions
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h400, 32'd1, 32'd2, Y0, 32'd1, 32'd2, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00318233;
        @(negedge clk);
        check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_no_ghost", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream clears outputs without a clock edge
        out_ready = 1'b0;
        issue(32'h12345397, 32'h500, 32'd1, 32'd2, Y0, 32'h500, 32'h1234_5000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_a", out_a, 32'd0);
        check("arst_out_b", out_b, 32'd0);
        check("arst_out_rd", {27'd0, out_rd}, 32'd0);
        check("arst_out_wb_en", {31'd0, out_wb_en}, 32'd0);
        check("arst_out_pc", out_pc, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(2);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
